// File: rtl/ocx_dlx_xlx_pkg.sv
// ocx_dlx_xlx_pkg
//   Shared definitions for the transceiver bring-up sequencer:
//   state encoding, default timing/retry parameters and a small
//   decode helper used to build the registered outputs.
package ocx_dlx_xlx_pkg;

  // Default parameter values for ocx_dlx_xlx_rst_seq.
  localparam int DEF_TIMEOUT_CYCLES = 1048576;  // ~6.7 ms at 156.25 MHz
  localparam int DEF_PULSE_CYCLES   = 8;        // must be >= 2
  localparam int DEF_MAX_RETRIES    = 3;        // must be <= 15

  typedef enum logic [2:0] {
    ST_HOLD    = 3'b000,
    ST_WAIT_TX = 3'b001,
    ST_WAIT_RX = 3'b010,
    ST_READY   = 3'b011,
    ST_RETRY   = 3'b100,
    ST_FAIL    = 3'b101
  } seq_state_e;

  // States in which the transceiver wizard is held in reset.
  function automatic logic drives_wiz_reset(input seq_state_e st);
    return (st == ST_HOLD) || (st == ST_RETRY);
  endfunction

endpackage

// File: rtl/ocx_dlx_sync2.sv
// ocx_dlx_sync2
//   1-bit two-flop synchronizer; both stages clear on reset.
//   Ports:
//     clk_i  destination clock
//     rst_i  asynchronous active-high reset
//     d_i    asynchronous input
//     q_o    synchronized output (2 cycles after d_i changes)
module ocx_dlx_sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ocx_dlx_xlx_rst_seq.sv
// ocx_dlx_xlx_rst_seq
//   Transceiver bring-up sequencer and watchdog. Stretches the reset
//   request from the DLx/Xilinx interface, waits for TX then RX bring-up,
//   re-pulses the wizard reset on timeout and, after MAX_RETRIES pulses,
//   raises a sticky failure flag.
//   Ports:
//     clk_156_25MHz                 reference clock for all state
//     reset                         asynchronous active-high reset
//     gtwiz_reset_all_in            reset request (priority over everything)
//     gtwiz_reset_tx_done_in        async TX reset done
//     gtwiz_buffbypass_tx_done_in   async TX buffer bypass done
//     gtwiz_userclk_tx_active_in    async TX user clock active
//     gtwiz_reset_rx_done_in        async RX reset done
//     gtwiz_buffbypass_rx_done_in   async RX buffer bypass done
//     gtwiz_userclk_rx_active_in    async RX user clock active
//     gtwiz_reset_all_out           registered wizard reset
//     phy_ready                     registered, TX and RX both up
//     phy_fail                      registered, sticky failure
//     retry_count                   registered, retries since READY/HOLD
//   PULSE_CYCLES must be >= 2 and MAX_RETRIES <= 15.
module ocx_dlx_xlx_rst_seq
  import ocx_dlx_xlx_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int PULSE_CYCLES   = DEF_PULSE_CYCLES,
  parameter int MAX_RETRIES    = DEF_MAX_RETRIES
) (
  input  logic       clk_156_25MHz,
  input  logic       reset,
  input  logic       gtwiz_reset_all_in,
  input  logic       gtwiz_reset_tx_done_in,
  input  logic       gtwiz_buffbypass_tx_done_in,
  input  logic       gtwiz_userclk_tx_active_in,
  input  logic       gtwiz_reset_rx_done_in,
  input  logic       gtwiz_buffbypass_rx_done_in,
  input  logic       gtwiz_userclk_rx_active_in,
  output logic       gtwiz_reset_all_out,
  output logic       phy_ready,
  output logic       phy_fail,
  output logic [3:0] retry_count
);

  localparam int TIMER_W = ($clog2(TIMEOUT_CYCLES) < 1) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam int PULSE_W = ($clog2(PULSE_CYCLES) < 1) ? 1 : $clog2(PULSE_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(PULSE_CYCLES - 1);
  localparam logic [3:0]         RETRY_MAX  = 4'(MAX_RETRIES);

  // Synchronize the six status inputs: bits [2:0] TX, bits [5:3] RX.
  logic [5:0] async_vec;
  logic [5:0] sync_vec;

  assign async_vec = {gtwiz_userclk_rx_active_in, gtwiz_buffbypass_rx_done_in,
                      gtwiz_reset_rx_done_in,     gtwiz_userclk_tx_active_in,
                      gtwiz_buffbypass_tx_done_in, gtwiz_reset_tx_done_in};

  for (genvar gi = 0; gi < 6; gi++) begin : g_sync
    ocx_dlx_sync2 u_sync (
      .clk_i (clk_156_25MHz),
      .rst_i (reset),
      .d_i   (async_vec[gi]),
      .q_o   (sync_vec[gi])
    );
  end

  logic tx_ok;
  logic rx_ok;
  assign tx_ok = &sync_vec[2:0];
  assign rx_ok = &sync_vec[5:3];

  seq_state_e         state_q,  state_d;
  logic [TIMER_W-1:0] timer_q,  timer_d;
  logic [PULSE_W-1:0] pulse_q,  pulse_d;
  logic [3:0]         retry_q,  retry_d;
  logic               wiz_rst_q, wiz_rst_d;
  logic               ready_q,  ready_d;
  logic               fail_q,   fail_d;

  always_ff @(posedge clk_156_25MHz or posedge reset) begin
    if (reset) begin
      state_q   <= ST_HOLD;
      timer_q   <= '0;
      pulse_q   <= '0;
      retry_q   <= '0;
      wiz_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pulse_q   <= pulse_d;
      retry_q   <= retry_d;
      wiz_rst_q <= wiz_rst_d;
      ready_q   <= ready_d;
      fail_q    <= fail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pulse_d = pulse_q;
    retry_d = retry_q;

    if (gtwiz_reset_all_in) begin
      state_d = ST_HOLD;
      timer_d = '0;
      pulse_d = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          // Counter saturates at PULSE_LAST, which is also the exit point.
          if (pulse_q == PULSE_LAST) begin
            state_d = ST_WAIT_TX;
            timer_d = '0;
          end else begin
            pulse_d = pulse_q + 1'b1;
          end
        end

        ST_WAIT_TX: begin
          // Completion is checked before the timeout so it wins a tie.
          if (tx_ok) begin
            state_d = ST_WAIT_RX;
            timer_d = '0;
          end else if (timer_q == TIMER_LAST) begin
            if (retry_q < RETRY_MAX) begin
              state_d = ST_RETRY;
              pulse_d = '0;
              retry_d = retry_q + 4'd1;
            end else begin
              state_d = ST_FAIL;
            end
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end

        ST_WAIT_RX: begin
          if (!tx_ok) begin
            // TX fell back: restart the TX wait without spending a retry.
            state_d = ST_WAIT_TX;
            timer_d = '0;
          end else if (rx_ok) begin
            state_d = ST_READY;
            retry_d = '0;
          end else if (timer_q == TIMER_LAST) begin
            if (retry_q < RETRY_MAX) begin
              state_d = ST_RETRY;
              pulse_d = '0;
              retry_d = retry_q + 4'd1;
            end else begin
              state_d = ST_FAIL;
            end
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end

        ST_READY: begin
          if (!tx_ok) begin
            state_d = ST_WAIT_TX;
            timer_d = '0;
          end else if (!rx_ok) begin
            state_d = ST_WAIT_RX;
            timer_d = '0;
          end
        end

        ST_RETRY: begin
          // Entered with pulse=0, so the wizard reset is high for exactly
          // PULSE_CYCLES cycles.
          if (pulse_q == PULSE_LAST) begin
            state_d = ST_WAIT_TX;
            timer_d = '0;
          end else begin
            pulse_d = pulse_q + 1'b1;
          end
        end

        ST_FAIL: begin
          state_d = ST_FAIL;
        end

        default: begin
          state_d = ST_HOLD;
          timer_d = '0;
          pulse_d = '0;
        end
      endcase
    end

    // Outputs decoded from the next state so they move with the state register.
    wiz_rst_d = drives_wiz_reset(state_d);
    ready_d   = (state_d == ST_READY);
    fail_d    = (state_d == ST_FAIL);
  end

  assign gtwiz_reset_all_out = wiz_rst_q;
  assign phy_ready           = ready_q;
  assign phy_fail            = fail_q;
  assign retry_count         = retry_q;

endmodule

// File: tb/tb_ocx_dlx_xlx_rst_seq.sv
// Testbench for ocx_dlx_xlx_rst_seq: directed bring-up scenarios followed by
// randomized episodes. Stimulus pushes expected outputs into a queue; a
// monitor pops one entry per clock and compares.
module tb_ocx_dlx_xlx_rst_seq;

  localparam int TO    = 64;
  localparam int PULSE = 8;
  localparam int MAXR  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req = 1'b0;
  logic [5:0] ain = '0;   // [2:0] TX status, [5:3] RX status
  logic       wiz_rst;
  logic       ready;
  logic       fail;
  logic [3:0] rcount;

  always #5 clk = ~clk;

  ocx_dlx_xlx_rst_seq #(
    .TIMEOUT_CYCLES (TO),
    .PULSE_CYCLES   (PULSE),
    .MAX_RETRIES    (MAXR)
  ) dut (
    .clk_156_25MHz               (clk),
    .reset                       (reset),
    .gtwiz_reset_all_in          (req),
    .gtwiz_reset_tx_done_in      (ain[0]),
    .gtwiz_buffbypass_tx_done_in (ain[1]),
    .gtwiz_userclk_tx_active_in  (ain[2]),
    .gtwiz_reset_rx_done_in      (ain[3]),
    .gtwiz_buffbypass_rx_done_in (ain[4]),
    .gtwiz_userclk_rx_active_in  (ain[5]),
    .gtwiz_reset_all_out         (wiz_rst),
    .phy_ready                   (ready),
    .phy_fail                    (fail),
    .retry_count                 (rcount)
  );

  typedef struct packed {
    logic       wiz_rst;
    logic       ready;
    logic       fail;
    logic [3:0] rc;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: phase plus a countdown of cycles remaining in it.
  localparam int PH_HOLD = 0, PH_TX = 1, PH_RX = 2, PH_UP = 3, PH_RETRY = 4, PH_FAIL = 5;
  int       ph = PH_HOLD;
  int       left = PULSE;
  int       retries = 0;
  bit [5:0] s1 = '0;
  bit [5:0] s2 = '0;
  bit       rst_prev = 1'b1;

  task automatic timeout_hit();
    if (retries < MAXR) begin
      ph = PH_RETRY;
      left = PULSE;
      retries++;
    end else begin
      ph = PH_FAIL;
    end
  endtask

  task automatic model_step(input bit r, input bit rq, input bit [5:0] a);
    bit tx_up, rx_up;
    if (r) begin
      ph = PH_HOLD; left = PULSE; retries = 0; s1 = '0; s2 = '0;
      return;
    end
    tx_up = &s2[2:0];
    rx_up = &s2[5:3];
    if (rq) begin
      ph = PH_HOLD; left = PULSE; retries = 0;
    end else begin
      case (ph)
        PH_HOLD, PH_RETRY: if (left == 1) begin ph = PH_TX; left = TO; end else left--;
        PH_TX: begin
          if (tx_up) begin ph = PH_RX; left = TO; end
          else if (left == 1) timeout_hit();
          else left--;
        end
        PH_RX: begin
          if (!tx_up) begin ph = PH_TX; left = TO; end
          else if (rx_up) begin ph = PH_UP; retries = 0; end
          else if (left == 1) timeout_hit();
          else left--;
        end
        PH_UP: begin
          if (!tx_up) begin ph = PH_TX; left = TO; end
          else if (!rx_up) begin ph = PH_RX; left = TO; end
        end
        default: ;
      endcase
    end
    s2 = s1;
    s1 = a;
  endtask

  // One clock of stimulus: drive at negedge, predict the post-edge outputs.
  task automatic cyc(input bit r, input bit rq, input bit [5:0] a);
    exp_t e;
    @(negedge clk);
    reset = r;
    req   = rq;
    ain   = a;
    if (r && !rst_prev) begin
      // Reset is asynchronous: outputs must be at reset values before any edge.
      #1;
      vectors++;
      if (wiz_rst !== 1'b1 || ready !== 1'b0 || fail !== 1'b0 || rcount !== 4'd0) begin
        miscompares++;
        $display("FAIL async_reset: got rst=%b rdy=%b fail=%b rc=%0d, want rst=1 rdy=0 fail=0 rc=0",
                 wiz_rst, ready, fail, rcount);
      end
    end
    rst_prev = r;
    model_step(r, rq, a);
    e.wiz_rst = (ph == PH_HOLD) || (ph == PH_RETRY);
    e.ready   = (ph == PH_UP);
    e.fail    = (ph == PH_FAIL);
    e.rc      = 4'(retries);
    exp_q.push_back(e);
  endtask

  task automatic run(input int n, input bit rq, input bit [5:0] a);
    repeat (n) cyc(1'b0, rq, a);
  endtask

  // Monitor: outputs are presented every cycle; compare one entry per edge.
  initial begin
    exp_t e, g;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = '{wiz_rst, ready, fail, rcount};
        vectors++;
        if (g !== e) begin
          miscompares++;
          $display("FAIL outputs @%0t: got rst=%b rdy=%b fail=%b rc=%0d, want rst=%b rdy=%b fail=%b rc=%0d",
                   $time, g.wiz_rst, g.ready, g.fail, g.rc, e.wiz_rst, e.ready, e.fail, e.rc);
        end
      end
    end
  end

  initial begin
    bit [2:0] txv, rxv;
    repeat (3) cyc(1'b1, 1'b0, 6'h00);

    // Nominal bring-up: TX at cycle 20, RX at cycle 40.
    for (int c = 0; c < 60; c++) begin
      txv = (c >= 20) ? 3'b111 : 3'b000;
      rxv = (c >= 40) ? 3'b111 : 3'b000;
      cyc(1'b0, 1'b0, {rxv, txv});
    end

    // Link drop: lose RX buffer bypass, then restore.
    run(10, 1'b0, 6'b101_111);
    run(10, 1'b0, 6'h3F);

    // Single retry, then bring everything up.
    run(1, 1'b1, 6'h00);
    run(80, 1'b0, 6'h00);
    run(30, 1'b0, 6'h3F);

    // Exhaustion into FAIL, then recovery via request.
    run(1, 1'b1, 6'h00);
    run(320, 1'b0, 6'h00);
    run(1, 1'b1, 6'h00);
    run(6, 1'b0, 6'h00);

    // Request during RETRY.
    run(1, 1'b1, 6'h00);
    run(76, 1'b0, 6'h00);
    run(2, 1'b1, 6'h00);
    run(20, 1'b0, 6'h3F);

    // Request during WAIT_RX.
    run(1, 1'b1, 6'h07);
    run(20, 1'b0, 6'h07);
    run(1, 1'b1, 6'h07);
    run(15, 1'b0, 6'h07);

    // Asynchronous reset while waiting for RX with the timer near 30.
    run(1, 1'b1, 6'h07);
    run(39, 1'b0, 6'h07);
    repeat (3) cyc(1'b1, 1'b0, 6'h07);
    run(20, 1'b0, 6'h3F);

    // Randomized episodes.
    for (int ep = 0; ep < 80; ep++) begin
      int r, len;
      bit er, eq;
      r   = $urandom_range(0, 99);
      er  = (r < 4);
      eq  = (r >= 4 && r < 12);
      len = (er || eq) ? $urandom_range(1, 3) : $urandom_range(1, 90);
      txv = ($urandom_range(0, 99) < 65) ? 3'b111 : 3'($urandom);
      rxv = ($urandom_range(0, 99) < 65) ? 3'b111 : 3'($urandom);
      repeat (len) cyc(er, eq, {rxv, txv});
    end

    @(posedge clk);
    #3;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
